urv_dm_ahb_bridge: RTL

Responder for the core's data-memory port: accepts single load/store requests from the execute stage and converts each one into one non-pipelined AHB-Lite master transfer. Returns load data, store completion and bus errors to the core. `dm_ready_o` is the back-pressure the execute stage stalls on. Sits between `urv_exec` and the system AHB-Lite interconnect.

---
 rtl/urv_dm_ahb_bridge.sv | 139 +++++++++++++
 1 files changed

// File: rtl/urv_dm_ahb_bridge.sv
// rtl/urv_dm_ahb_bridge.sv - data-memory port to single non-pipelined AHB-Lite master transfers
module urv_dm_ahb_bridge (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  output logic [31:0] haddr_o,
  output logic [1:0]  htrans_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [3:0]  hprot_o,
  output logic [31:0] hwdata_o,
  input  logic [31:0] hrdata_i,
  input  logic        hready_i,
  input  logic        hresp_i
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  logic        accept;
  logic        bad_store;
  logic        finish;
  logic        sel_ok;
  logic [1:0]  sel_off;
  logic [2:0]  sel_size;
  logic        addr_lsb_unused;

  // Stores take their lane offset from the select, so the address low bits are not needed.
  assign addr_lsb_unused = ^dm_addr_i[1:0];

  assign hburst_o = 3'b000;
  assign hprot_o  = 4'b0011;

  // Decode the byte-lane select into an AHB size and address offset.
  always_comb begin
    sel_ok   = 1'b1;
    sel_off  = 2'b00;
    sel_size = 3'b010;
    case (dm_data_select_i)
      4'b1111: begin sel_size = 3'b010; sel_off = 2'b00; end
      4'b0011: begin sel_size = 3'b001; sel_off = 2'b00; end
      4'b1100: begin sel_size = 3'b001; sel_off = 2'b10; end
      4'b0001: begin sel_size = 3'b000; sel_off = 2'b00; end
      4'b0010: begin sel_size = 3'b000; sel_off = 2'b01; end
      4'b0100: begin sel_size = 3'b000; sel_off = 2'b10; end
      4'b1000: begin sel_size = 3'b000; sel_off = 2'b11; end
      default: sel_ok = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and bus-phase outputs; a store with an unusable select completes without a transfer.
  always_comb begin
    state_d    = state_q;
    dm_ready_o = 1'b0;
    htrans_o   = HTRANS_IDLE;
    accept     = 1'b0;
    bad_store  = 1'b0;
    finish     = 1'b0;
    case (state_q)
      S_IDLE: begin
        dm_ready_o = 1'b1;
        if (dm_load_i || dm_store_i) begin
          if (dm_store_i && !sel_ok) begin
            bad_store = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        htrans_o = HTRANS_NONSEQ;
        if (hready_i) state_d = S_DATA;
      end
      S_DATA: begin
        if (hready_i) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture address, control and write data at accept; held for the whole transfer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      haddr_o  <= 32'h0;
      hsize_o  <= 3'b010;
      hwrite_o <= 1'b0;
      hwdata_o <= 32'h0;
    end else if (accept) begin
      hwrite_o <= dm_store_i;
      if (dm_store_i) begin
        haddr_o  <= {dm_addr_i[31:2], sel_off};
        hsize_o  <= sel_size;
        hwdata_o <= dm_data_s_i;
      end else begin
        haddr_o  <= {dm_addr_i[31:2], 2'b00};
        hsize_o  <= 3'b010;
      end
    end
  end

  // Completion pulses and load data, registered one cycle after the data phase ends.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_error_o      <= 1'b0;
      dm_data_l_o     <= 32'h0;
    end else begin
      dm_load_done_o  <= finish && !hwrite_o;
      dm_store_done_o <= (finish && hwrite_o) || bad_store;
      dm_error_o      <= (finish && hresp_i) || bad_store;
      if (finish && !hwrite_o) dm_data_l_o <= hresp_i ? 32'h0 : hrdata_i;
    end
  end

endmodule
